// File: rtl/clk_div_pkg.sv
// Shared types and frequency constants for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int unsigned TC_1HZ   = 49_999_999;
    localparam int unsigned TC_1KHZ  = 49_999;
    localparam int unsigned TC_190HZ = 262_143;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: FSM, counter, terminal count and shadow terminal count.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned DEFAULT_TC = TC_1HZ
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             en,
    input  logic             oneshot,
    input  logic             load,
    input  logic [CNT_W-1:0] load_tc,
    output logic             clk_out,
    output logic             tick,
    output logic             done,
    output logic             busy
);

    ch_state_e        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] tc_q, tc_n;
    logic [CNT_W-1:0] shadow_q, shadow_n;
    logic             pend_q, pend_n;
    logic             mode_q, mode_n;
    logic             clk_out_n, tick_n, done_n, busy_n;
    logic             hit;

    assign hit = (cnt_q == tc_q);

    // State and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tc_q     <= CNT_W'(DEFAULT_TC);
            shadow_q <= '0;
            pend_q   <= 1'b0;
            mode_q   <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            tc_q     <= tc_n;
            shadow_q <= shadow_n;
            pend_q   <= pend_n;
            mode_q   <= mode_n;
            clk_out  <= clk_out_n;
            tick     <= tick_n;
            done     <= done_n;
            busy     <= busy_n;
        end
    end

    // Next-state logic; tc only changes outside RUN or exactly at a toggle.
    always_comb begin
        state_n   = state_q;
        cnt_n     = '0;
        tc_n      = tc_q;
        shadow_n  = shadow_q;
        pend_n    = pend_q;
        mode_n    = mode_q;
        clk_out_n = 1'b0;
        tick_n    = 1'b0;
        done_n    = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (!en) begin
                    state_n = ST_IDLE;
                end else if (hit) begin
                    if (pend_q) begin
                        tc_n   = shadow_q;
                        pend_n = 1'b0;
                    end
                    clk_out_n = ~clk_out;
                    tick_n    = ~clk_out;
                    if (clk_out && mode_q) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n     = cnt_q + CNT_W'(1);
                    clk_out_n = clk_out;
                end
                // A load while running waits in the shadow for the next toggle.
                if (load) begin
                    shadow_n = load_tc;
                    pend_n   = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                // Outside RUN a load is immediate; a leftover shadow is committed.
                if (load) begin
                    tc_n   = load_tc;
                    pend_n = 1'b0;
                end else if (pend_q) begin
                    tc_n   = shadow_q;
                    pend_n = 1'b0;
                end
                if (state_q == ST_IDLE) begin
                    if (en) begin
                        state_n = ST_RUN;
                        mode_n  = oneshot;
                    end
                end else if (!en) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_RUN);
    end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent runtime-programmable clock dividers sharing one load port.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int unsigned N_CH       = 4,
    parameter  int unsigned CNT_W      = 27,
    parameter  int unsigned DEFAULT_TC = TC_1HZ,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  oneshot,
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0] load_tc,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  done,
    output logic [N_CH-1:0]  busy
);

    logic [N_CH-1:0] load_sel;

    // Route the load strobe to one channel; out-of-range selects match nothing.
    always_comb begin
        load_sel = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            load_sel[i] = load && (32'(load_ch) == i);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W      (CNT_W),
            .DEFAULT_TC (DEFAULT_TC)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .en         (en[g]),
            .oneshot    (oneshot[g]),
            .load       (load_sel[g]),
            .load_tc    (load_tc),
            .clk_out    (clk_out[g]),
            .tick       (tick[g]),
            .done       (done[g]),
            .busy       (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a countdown reference model predicts each cycle's outputs.
module tb_clk_div_multi;

    localparam int unsigned N_CH       = 3;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned DEFAULT_TC = 3;
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef struct packed {
        logic [N_CH-1:0] clk_out;
        logic [N_CH-1:0] tick;
        logic [N_CH-1:0] done;
        logic [N_CH-1:0] busy;
    } obs_t;

    logic             clk_100MHz = 1'b0;
    logic             reset      = 1'b1;
    logic [N_CH-1:0]  en         = '0;
    logic [N_CH-1:0]  oneshot    = '0;
    logic             load       = 1'b0;
    logic [CH_W-1:0]  load_ch    = '0;
    logic [CNT_W-1:0] load_tc    = '0;
    logic [N_CH-1:0]  clk_out, tick, done, busy;

    clk_div_multi #(
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .DEFAULT_TC (DEFAULT_TC)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .en         (en),
        .oneshot    (oneshot),
        .load       (load),
        .load_ch    (load_ch),
        .load_tc    (load_tc),
        .clk_out    (clk_out),
        .tick       (tick),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    obs_t exp_q[$];
    obs_t exp_o, act_o;

    // Reference model: phase 0 idle, 1 running, 2 finished one-shot.
    int m_phase [N_CH];
    int m_tc    [N_CH];
    int m_sh    [N_CH];
    int m_left  [N_CH];
    bit m_pend  [N_CH];
    bit m_mode  [N_CH];
    bit m_lvl   [N_CH];

    logic [N_CH-1:0] cur_en = '0;
    logic [N_CH-1:0] cur_os = '0;

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_phase[c] = 0; m_tc[c] = DEFAULT_TC; m_sh[c] = 0; m_left[c] = 0;
            m_pend[c] = 0; m_mode[c] = 0; m_lvl[c] = 0;
        end
    endtask

    // Advance the model one clock: each half-period lasts tc+1 cycles, counted down.
    task automatic model_step(input bit ld, input int ch, input int tcv, output obs_t o);
        o = '0;
        for (int c = 0; c < N_CH; c++) begin
            bit mine;
            mine = ld && (ch == c);
            if (m_phase[c] == 1) begin
                if (!cur_en[c]) begin
                    m_phase[c] = 0;
                    m_lvl[c]   = 0;
                end else begin
                    m_left[c] = m_left[c] - 1;
                    if (m_left[c] == 0) begin
                        if (m_pend[c]) begin m_tc[c] = m_sh[c]; m_pend[c] = 0; end
                        m_lvl[c] = !m_lvl[c];
                        if (m_lvl[c]) o.tick[c] = 1'b1;
                        else if (m_mode[c]) begin m_phase[c] = 2; o.done[c] = 1'b1; end
                        m_left[c] = m_tc[c] + 1;
                    end
                end
                if (mine) begin m_sh[c] = tcv; m_pend[c] = 1; end
            end else begin
                if (mine) begin m_tc[c] = tcv; m_pend[c] = 0; end
                else if (m_pend[c]) begin m_tc[c] = m_sh[c]; m_pend[c] = 0; end
                if (m_phase[c] == 2) begin
                    if (!cur_en[c]) m_phase[c] = 0;
                end else if (cur_en[c]) begin
                    m_phase[c] = 1;
                    m_mode[c]  = cur_os[c];
                    m_left[c]  = m_tc[c] + 1;
                    m_lvl[c]   = 0;
                end
            end
            o.clk_out[c] = m_lvl[c];
            o.busy[c]    = (m_phase[c] == 1);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the predicted response.
    task automatic step(input bit ld = 0, input int ch = 0, input int tcv = 0);
        obs_t o;
        @(negedge clk_100MHz);
        en      = cur_en;
        oneshot = cur_os;
        load    = ld;
        load_ch = CH_W'(ch);
        load_tc = CNT_W'(tcv);
        model_step(ld, ch, tcv, o);
        exp_q.push_back(o);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if ({clk_out, tick, done, busy} != '0) begin
            n_bad++;
            $display("FAIL %s: outputs got %h expected 0", tag, {clk_out, tick, done, busy});
        end
    endtask

    // Monitor: compare DUT outputs with the queued prediction just after each rising edge.
    always @(posedge clk_100MHz) begin
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            exp_o = exp_q.pop_front();
            act_o = {clk_out, tick, done, busy};
            n_cmp++;
            if (act_o !== exp_o) begin
                n_bad++;
                $display("FAIL cyc%0d: clk_out/tick/done/busy got %b/%b/%b/%b expected %b/%b/%b/%b",
                         cyc, act_o.clk_out, act_o.tick, act_o.done, act_o.busy,
                         exp_o.clk_out, exp_o.tick, exp_o.done, exp_o.busy);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_100MHz);
        #2;
        check_zero("reset_hold");
        @(negedge clk_100MHz);
        reset = 1'b0;

        // Channel 0 continuous at the default terminal count.
        cur_en = 3'b001;
        run(24);

        // Channel 1 one-shot with tc=1 loaded while idle, then re-triggered.
        step(1, 1, 1);
        cur_en = 3'b011; cur_os = 3'b010;
        run(10);
        cur_en[1] = 1'b0;
        run(2);
        cur_en[1] = 1'b1;
        run(8);
        cur_en[1] = 1'b0;
        run(2);

        // Running channel 0: two loads before the toggle, the last one wins.
        step(1, 0, 0);
        step(1, 0, 2);
        run(16);
        step(1, 0, 0);
        run(8);

        // Channel 2 aborted mid-period, then restarted from zero.
        cur_os = 3'b000;
        step(1, 2, 4);
        cur_en = 3'b101;
        run(6);
        cur_en[2] = 1'b0;
        run(3);
        cur_en[2] = 1'b1;
        run(14);

        // Out-of-range channel select must leave every terminal count untouched.
        step(1, 3, 0);
        run(20);

        // Randomised traffic including loads that land on toggle cycles.
        for (int i = 0; i < 700; i++) begin
            bit ld;
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 11) == 0) begin
                    cur_en[c] = ~cur_en[c];
                    cur_os[c] = 1'($urandom_range(0, 1));
                end
            end
            ld = ($urandom_range(0, 3) == 0);
            step(ld, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        // Asynchronous reset while every channel runs.
        cur_en = 3'b111; cur_os = 3'b000;
        step(1, 0, 5);
        step(1, 1, 0);
        step(1, 2, 1);
        run(12);
        @(posedge clk_100MHz);
        #3;
        reset  = 1'b1;
        cur_en = '0;
        en     = '0;
        load   = 1'b0;
        #1;
        check_zero("async_reset_immediate");
        @(posedge clk_100MHz);
        #2;
        check_zero("async_reset_held");
        model_reset();
        @(negedge clk_100MHz);
        reset = 1'b0;

        // After release: idle until enabled, and the default terminal count is back.
        run(4);
        cur_en = 3'b001;
        run(20);
        cur_en = 3'b111;
        run(20);

        @(posedge clk_100MHz);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending predictions got %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised successor to the single-channel 1 Hz divider. Generates N_CH independent divided clocks from the 100 MHz Basys 3 board clock.
- Each channel has:
  - a runtime-loadable terminal count;
  - an enable;
  - a continuous/one-shot mode;
  - a one-cycle tick strobe.
- Feeds the EVM's display refresh, debounce sampling, buzzer and vote-timeout logic. Consumers use tick as a clock enable rather than clocking from clk_out.

Parameters:
- N_CH, 4, number of independent channels (1..8).
- CNT_W, 27, counter and terminal-count width.
- DEFAULT_TC, 49_999_999, terminal count every channel holds after reset (1 Hz at 100 MHz).
- CH_W, $clog2(N_CH) (min 1), channel-select width; localparam.

Ports:
- clk_100MHz  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- en  in  N_CH  per-channel run enable, level.
- oneshot  in  N_CH  per-channel mode: 0 continuous, 1 one-shot; sampled on IDLE->RUN.
- load  in  1  one-cycle strobe; writes load_tc to channel load_ch.
- load_ch  in  CH_W  target channel of load.
- load_tc  in  CNT_W  new terminal count; half-period = load_tc+1 cycles.
- clk_out  out  N_CH  50% duty square wave per channel.
- tick  out  N_CH  one-cycle pulse on the cycle clk_out goes 0->1.
- done  out  N_CH  one-cycle pulse when a one-shot channel finishes.
- busy  out  N_CH  1 while channel is in RUN.

Behaviour:
- Reset (async assert, sync release):
  - all counters = 0, clk_out = 0, tick = 0, done = 0, busy = 0;
  - tc = DEFAULT_TC, pending_valid = 0, all channels IDLE.
- Per-channel FSM states: IDLE, RUN, DONE.
- IDLE:
  - counter = 0, clk_out = 0.
  - en=1 -> RUN next cycle; latch oneshot into mode_q.
- RUN:
  - counter increments each cycle.
  - When counter == tc: counter <= 0 and clk_out toggles. On 0->1, tick = 1 for that same registered cycle.
  - Period = 2*(tc+1) cycles. First rising edge of clk_out occurs tc+1 cycles after entering RUN.
  - mode_q=1: on the toggle 1->0 (first full period complete) -> DONE, done pulses 1 cycle, clk_out = 0.
  - en=0 in RUN -> IDLE next cycle. Abort mid-period: clk_out forced 0, no tick, no done.
- DONE:
  - Holds clk_out = 0, busy = 0.
  - en=0 -> IDLE. Re-trigger requires en low then high.
- Load rules:
  - load_ch >= N_CH: load ignored.
  - Target channel IDLE or DONE: tc updated the cycle after load.
  - Target channel RUN: value goes to a shadow register (pending_valid = 1) and is applied at the next toggle (counter == tc event). Glitch-free, no truncated half-period.
  - Second load before the toggle overwrites the shadow; last value wins.
  - Load on the same cycle as a toggle: the old tc completes this half-period and the new value applies at the following toggle.
- load_tc = 0: toggles every cycle (clk/2). tick every 2nd cycle.
- Counter compare is equality only. A shadow swap always coincides with counter reset, so counter > tc cannot occur.
- Outputs are registered, with no combinational path from inputs. Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Shared package clk_div_pkg holds:
  - FSM state enum (IDLE/RUN/DONE);
  - default constants CLK_HZ = 100_000_000 and TC_1HZ = 49_999_999;
  - TC_1KHZ = 49_999;
  - TC_190HZ = 262_143 (display refresh).
- Sub-module clk_div_ch: one channel (FSM, counter, tc, shadow), instantiated N_CH times via generate. The top level only decodes load/load_ch.

Test Plan:
- Reset, DEFAULT_TC overridden to 3, en[0]=1 continuous -> tick[0] first at cycle 4 after RUN, then every 8 cycles. clk_out[0] high 4 / low 4.
- Load ch1 tc=1 while ch1 IDLE, en[1]=1, oneshot[1]=1 -> clk_out[1] high 2 cycles, low 2 cycles. done[1] pulses once, busy[1] falls. No further ticks until en[1] toggles 0->1.
- Ch0 running tc=3, load tc=0 mid half-period -> current half-period completes at 4 cycles, then toggles every cycle. Second load before the toggle: only the last value takes effect.
- en[2] dropped mid-period -> clk_out[2] = 0 next cycle, no tick, no done. Re-enable restarts from counter 0.
- load_ch = N_CH (N_CH=3 build) -> no tc changes on any channel.
- Assert reset while all channels run -> all outputs 0 immediately (asynchronous). After release, tc back to DEFAULT_TC and channels stay IDLE until en is seen high.
